bsg_cgol_job_arb: RTL and testbench
===================================

// Module: bsg_cgol_job_arb
// PURPOSE
//  Round-robin job scheduler that shares one CGOL engine (ctrl + cell array) among num_req_p requesters.
//  Accepts {board, frames} jobs, issues one at a time on the engine input channel (v/ready).
//  Collects the engine result (v/yumi) and returns it to the originating requester (v/yumi).
//  Sits between host-side requesters and the engine input/output channels.
// PARAMETERS
//  num_req_p          4     requester count (>=2); id_width_lp = BSG_SAFE_CLOG2(num_req_p)
//  max_game_length_p  1024  max frames per job; game_len_width_lp = BSG_SAFE_CLOG2(max_game_length_p)
//  board_width_p      8     board edge; board_bits_lp = board_width_p*board_width_p
//  timeout_p          4096  watchdog limit in cycles; used only with BSG_CGOL_JOB_ARB_TIMEOUT_EN
// PORTS
//  clk_i          in   1                         clock; all state on posedge
//  reset_n_i      in   1                         asynchronous, active-low reset
//  req_v_i        in   num_req_p                 per-requester job valid
//  req_frames_i   in   num_req_p*game_len_width  packed frame counts, slot i = requester i
//  req_board_i    in   num_req_p*board_bits      packed initial boards
//  req_ready_o    out  num_req_p                 one-hot accept; transfer = req_v_i[i] & req_ready_o[i]
//  resp_v_o       out  num_req_p                 one-hot result valid
//  resp_board_o   out  board_bits                result board (shared across requesters)
//  resp_err_o     out  1                         result is a timeout abort (0 without macro)
//  resp_yumi_i    in   num_req_p                 per-requester result consume
//  eng_v_o        out  1                         engine job valid
//  eng_frames_o   out  game_len_width            engine frame count
//  eng_board_o    out  board_bits                engine initial board
//  eng_ready_i    in   1                         engine accepts a job
//  eng_v_i        in   1                         engine result valid
//  eng_board_i    in   board_bits                engine result board
//  eng_yumi_o     out  1                         engine result consumed
//  busy_o         out  1                         state != eIDLE
//  grant_id_o     out  id_width                  id of the job in flight
// BEHAVIOUR
//  Reset: state=eIDLE, rr_ptr=0, grant=0, latches 0. All outputs 0 except req_ready_o, which is combinational in eIDLE.
//  States:
//   - eIDLE: grant = first i with req_v_i[i], scanning from rr_ptr upward with wrap.
//     req_ready_o = onehot(grant) the same cycle (comb); no req_v_i -> all 0.
//     On transfer: latch frames/board/grant.
//     frames!=0 -> eISSUE. frames==0 -> bypass: result = latched board, -> eRETURN.
//   - eISSUE: eng_v_o=1 with latched frames/board, held stable until eng_ready_i; then -> eRUN.
//   - eRUN: eng_yumi_o = eng_v_i. On eng_v_i, latch eng_board_i, err=0, -> eRETURN.
//   - eRETURN: resp_v_o = onehot(grant), resp_board_o/resp_err_o = latched values, stable until consumed.
//     On resp_yumi_i[grant]: -> eIDLE, rr_ptr = (grant==num_req_p-1) ? 0 : grant+1.
//  Latency: grant to eng_v_o = 1 cycle. Engine result to resp_v_o = 1 cycle.
//   Bypass job: accept to resp_v_o = 1 cycle.
//  One job in flight max. No new req_ready_o outside eIDLE.
//  resp_yumi_i from a non-granted requester is ignored.
//  req_v_i may drop before a grant; it is sampled only in eIDLE.
//  Simultaneous requests: strict round robin from rr_ptr. Each requester waits at most num_req_p-1 jobs.
//  rr_ptr is updated only on response consume; a bypass job also advances it.
//  eng_v_i outside eRUN (stale result after abort): eng_yumi_o=1, data dropped, no state change.
//  Reset asserted mid-job: immediate return to reset values. The engine shares reset_n_i; no job survives.
// CONFIGURATION
//  BSG_CGOL_JOB_ARB_TIMEOUT_EN defined:
//   - 32-bit watchdog cleared on entering eRUN, incremented each eRUN cycle.
//   - Reaching timeout_p with no eng_v_i: -> eRETURN with err=1, result = original board.
//   - eng_v_i in the same cycle as expiry wins: normal result, err=0.
//  Undefined: no watchdog logic, resp_err_o tied 0, stale-drop path is unreachable.
// TESTING
//  1) reset_n_i low mid-eRUN -> next edge: busy_o=0, resp_v_o=0, eng_v_o=0. req_ready_o follows req_v_i in eIDLE.
//  2) req_v_i=4'b0001, frames=5, board=glider; engine returns after 7 cycles ->
//     eng_v_o 1 cycle after accept; resp_v_o=4'b0001 with engine board 1 cycle after eng_v_i; err=0.
//  3) req_v_i=4'b1111 held, engine result after 3 cycles, yumi immediately ->
//     grant order 0,1,2,3,0; grant_id_o matches each time.
//  4) rr_ptr=2, req_v_i=4'b0011 -> grant 0. Then req_v_i=4'b1011 -> grant 1; wrap is correct.
//  5) frames=0 on req 2 -> eng_v_o never asserts; resp_v_o[2]=1 next cycle with input board.
//     resp_yumi_i[1] pulsed there is ignored; resp_v_o stays until resp_yumi_i[2].
//  6) TIMEOUT_EN, timeout_p=16, engine silent -> resp_err_o=1 after 16 eRUN cycles with original board.
//     Late eng_v_i is yumi'd in eIDLE and dropped; next job completes normally.

Source files
------------

// File: rtl/bsg_cgol_job_arb_if.sv
// +----------------------------------------------------------------------------+
// | Module : bsg_cgol_job_arb_if                                                |
// | Brief  : Requester, response and engine channels of the CGOL job arbiter.   |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bsg_cgol_job_arb_if #(
  parameter int NUM_REQ_P  = 4,
  parameter int GAME_LEN_W = 10,
  parameter int BOARD_BITS = 64,
  parameter int ID_W       = 2
);
  logic [NUM_REQ_P-1:0]            req_v_i;
  logic [NUM_REQ_P*GAME_LEN_W-1:0] req_frames_i;
  logic [NUM_REQ_P*BOARD_BITS-1:0] req_board_i;
  logic [NUM_REQ_P-1:0]            req_ready_o;
  logic [NUM_REQ_P-1:0]            resp_v_o;
  logic [BOARD_BITS-1:0]           resp_board_o;
  logic                            resp_err_o;
  logic [NUM_REQ_P-1:0]            resp_yumi_i;
  logic                            eng_v_o;
  logic [GAME_LEN_W-1:0]           eng_frames_o;
  logic [BOARD_BITS-1:0]           eng_board_o;
  logic                            eng_ready_i;
  logic                            eng_v_i;
  logic [BOARD_BITS-1:0]           eng_board_i;
  logic                            eng_yumi_o;
  logic                            busy_o;
  logic [ID_W-1:0]                 grant_id_o;

  modport slave (
    input  req_v_i, req_frames_i, req_board_i, resp_yumi_i,
           eng_ready_i, eng_v_i, eng_board_i,
    output req_ready_o, resp_v_o, resp_board_o, resp_err_o,
           eng_v_o, eng_frames_o, eng_board_o, eng_yumi_o, busy_o, grant_id_o
  );

  modport master (
    output req_v_i, req_frames_i, req_board_i, resp_yumi_i,
           eng_ready_i, eng_v_i, eng_board_i,
    input  req_ready_o, resp_v_o, resp_board_o, resp_err_o,
           eng_v_o, eng_frames_o, eng_board_o, eng_yumi_o, busy_o, grant_id_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_cgol_job_arb.sv
// +----------------------------------------------------------------------------+
// | Module : bsg_cgol_job_arb                                                   |
// | Brief  : Round-robin scheduler sharing one CGOL engine among requesters.    |
// |          Optional watchdog abort: define BSG_CGOL_JOB_ARB_TIMEOUT_EN.       |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsg_cgol_job_arb #(
  parameter int NUM_REQ_P         = 4,
  parameter int MAX_GAME_LENGTH_P = 1024,
  parameter int BOARD_WIDTH_P     = 8,
  parameter int TIMEOUT_P         = 4096
) (
  input  wire logic            clk_i,
  input  wire logic            reset_n_i,
  bsg_cgol_job_arb_if.slave    bus
);

  localparam int c_id_w   = (NUM_REQ_P <= 1) ? 1 : $clog2(NUM_REQ_P);
  localparam int c_glen_w = (MAX_GAME_LENGTH_P <= 1) ? 1 : $clog2(MAX_GAME_LENGTH_P);
  localparam int c_bbits  = BOARD_WIDTH_P * BOARD_WIDTH_P;

  typedef enum logic [1:0] {
    eIDLE   = 2'd0,
    eISSUE  = 2'd1,
    eRUN    = 2'd2,
    eRETURN = 2'd3
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [c_id_w-1:0]     r_rr_ptr;
  logic [c_id_w-1:0]     r_grant;
  logic [c_glen_w-1:0]   r_frames;
  logic [c_bbits-1:0]    r_board;
  logic [c_bbits-1:0]    r_result;

  logic                  w_found;
  logic [c_id_w-1:0]     w_sel;
  int                    w_idx;
  logic [c_glen_w-1:0]   w_sel_frames;
  logic [c_bbits-1:0]    w_sel_board;
  logic [NUM_REQ_P-1:0]  w_req_ready;
  logic                  w_accept;
  logic                  w_eng_done;
  logic                  w_resp_take;
  logic                  w_timeout;

  // Rotating priority scan: first valid requester at or after r_rr_ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ_P) begin
        w_idx = w_idx - NUM_REQ_P;
      end
      if (!w_found && bus.req_v_i[c_id_w'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = c_id_w'(w_idx);
      end
    end
  end

  assign w_sel_frames = bus.req_frames_i[w_sel*c_glen_w +: c_glen_w];
  assign w_sel_board  = bus.req_board_i[w_sel*c_bbits +: c_bbits];

`ifdef BSG_CGOL_JOB_ARB_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_err;
  assign w_timeout = (r_state == eRUN) && !bus.eng_v_i && (r_wd == 32'(TIMEOUT_P - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_eng_done  = 1'b0;
    w_resp_take = 1'b0;
    case (r_state)
      eIDLE: begin
        if (w_found) begin
          w_req_ready = NUM_REQ_P'(1) << w_sel;
          w_accept    = 1'b1;
          w_state_nxt = (w_sel_frames != '0) ? eISSUE : eRETURN;
        end
      end
      eISSUE: begin
        if (bus.eng_ready_i) begin
          w_state_nxt = eRUN;
        end
      end
      eRUN: begin
        if (bus.eng_v_i) begin
          w_eng_done  = 1'b1;
          w_state_nxt = eRETURN;
        end else if (w_timeout) begin
          w_state_nxt = eRETURN;
        end
      end
      eRETURN: begin
        if (bus.resp_yumi_i[r_grant]) begin
          w_resp_take = 1'b1;
          w_state_nxt = eIDLE;
        end
      end
      default: w_state_nxt = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= eIDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_frames <= '0;
      r_board  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_grant  <= w_sel;
        r_frames <= w_sel_frames;
        r_board  <= w_sel_board;
        // Zero-frame jobs never touch the engine: the input board is the result.
        if (w_sel_frames == '0) begin
          r_result <= w_sel_board;
        end
      end
      if (w_eng_done) begin
        r_result <= bus.eng_board_i;
      end else if (w_timeout) begin
        r_result <= r_board;
      end
      if (w_resp_take) begin
        r_rr_ptr <= (r_grant == c_id_w'(NUM_REQ_P - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

`ifdef BSG_CGOL_JOB_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == eISSUE && bus.eng_ready_i) begin
        r_wd <= '0;
      end else if (r_state == eRUN) begin
        r_wd <= r_wd + 32'd1;
      end
      if (w_accept || w_eng_done) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.resp_err_o = r_err;
  // After an abort the engine may still deliver; swallow it in any state.
  assign bus.eng_yumi_o = bus.eng_v_i;
`else
  assign bus.resp_err_o = 1'b0;
  assign bus.eng_yumi_o = (r_state == eRUN) && bus.eng_v_i;
`endif

  assign bus.req_ready_o  = w_req_ready;
  assign bus.resp_v_o     = (r_state == eRETURN) ? (NUM_REQ_P'(1) << r_grant) : '0;
  assign bus.resp_board_o = r_result;
  assign bus.eng_v_o      = (r_state == eISSUE);
  assign bus.eng_frames_o = r_frames;
  assign bus.eng_board_o  = r_board;
  assign bus.busy_o       = (r_state != eIDLE);
  assign bus.grant_id_o   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_bsg_cgol_job_arb.sv
// +----------------------------------------------------------------------------+
// | Module : tb_bsg_cgol_job_arb                                                |
// | Brief  : Directed self-checking bench for bsg_cgol_job_arb.                 |
// | Rev    : 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bsg_cgol_job_arb;
  localparam int N   = 4;
  localparam int GLW = 10;
  localparam int BB  = 64;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bsg_cgol_job_arb_if #(.NUM_REQ_P(N), .GAME_LEN_W(GLW), .BOARD_BITS(BB), .ID_W(IDW)) bus ();

  bsg_cgol_job_arb #(
    .NUM_REQ_P(N), .MAX_GAME_LENGTH_P(1024), .BOARD_WIDTH_P(8), .TIMEOUT_P(16)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  function automatic logic [BB-1:0] board_of(input int i);
    logic [7:0] b;
    b = 8'(8'hA0 + i);
    return {8{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input int frames, input logic [BB-1:0] board);
    bus.req_frames_i[i*GLW +: GLW] = GLW'(frames);
    bus.req_board_i[i*BB +: BB]    = board;
  endtask

  // One engine job for requester g; engine answers in its third run cycle.
  task automatic run_job(input int g, input logic [BB-1:0] res);
    logic [N-1:0] oh;
    oh = N'(1) << g;
    #1;
    n_total++; if (bus.req_ready_o !== oh) $display("FAIL job_ready g=%0d: got %b want %b", g, bus.req_ready_o, oh); else n_pass++;
    tick();
    n_total++; if (bus.eng_v_o !== 1'b1 || bus.grant_id_o !== IDW'(g)) $display("FAIL job_issue g=%0d: eng_v %b grant %0d want 1/%0d", g, bus.eng_v_o, bus.grant_id_o, g); else n_pass++;
    n_total++; if (bus.eng_frames_o !== GLW'(g + 1) || bus.eng_board_o !== board_of(g)) $display("FAIL job_payload g=%0d: got %0d/%h want %0d/%h", g, bus.eng_frames_o, bus.eng_board_o, g + 1, board_of(g)); else n_pass++;
    bus.eng_ready_i = 1'b1;
    tick();
    bus.eng_ready_i = 1'b0;
    tick();
    tick();
    bus.eng_v_i = 1'b1;
    bus.eng_board_i = res;
    tick();
    bus.eng_v_i = 1'b0;
    n_total++; if (bus.resp_v_o !== oh || bus.resp_board_o !== res || bus.resp_err_o !== 1'b0) $display("FAIL job_resp g=%0d: got %b/%h/%b want %b/%h/0", g, bus.resp_v_o, bus.resp_board_o, bus.resp_err_o, oh, res); else n_pass++;
    bus.resp_yumi_i = oh;
    tick();
    bus.resp_yumi_i = '0;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL job_done g=%0d: busy got %b want 0", g, bus.busy_o); else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++; if (bus.busy_o !== 1'b0 || bus.resp_v_o !== '0 || bus.eng_v_o !== 1'b0) $display("FAIL reset_outs: busy %b resp_v %b eng_v %b want 0", bus.busy_o, bus.resp_v_o, bus.eng_v_o); else n_pass++;
    n_total++; if (bus.grant_id_o !== '0 || bus.resp_board_o !== '0 || bus.resp_err_o !== 1'b0 || bus.req_ready_o !== '0) $display("FAIL reset_regs: grant %0d board %h err %b ready %b", bus.grant_id_o, bus.resp_board_o, bus.resp_err_o, bus.req_ready_o); else n_pass++;
    bus.req_v_i = 4'b0100;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b0100) $display("FAIL reset_ready: got %b want 0100", bus.req_ready_o); else n_pass++;
    bus.req_v_i = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [BB-1:0] glider;
    logic [BB-1:0] res;
    glider = 64'h0000_0000_0070_1020;
    res    = 64'h0000_0000_3850_4000;
    put(0, 5, glider);
    bus.req_v_i = 4'b0001;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b0001) $display("FAIL basic_ready: got %b want 0001", bus.req_ready_o); else n_pass++;
    tick();
    bus.req_v_i = '0;
    n_total++; if (bus.eng_v_o !== 1'b1 || bus.eng_frames_o !== 10'd5 || bus.eng_board_o !== glider) $display("FAIL basic_issue: got %b/%0d/%h want 1/5/%h", bus.eng_v_o, bus.eng_frames_o, bus.eng_board_o, glider); else n_pass++;
    tick();
    n_total++; if (bus.eng_v_o !== 1'b1 || bus.eng_board_o !== glider) $display("FAIL basic_hold: got %b/%h want 1/%h", bus.eng_v_o, bus.eng_board_o, glider); else n_pass++;
    bus.eng_ready_i = 1'b1;
    tick();
    bus.eng_ready_i = 1'b0;
    n_total++; if (bus.eng_v_o !== 1'b0 || bus.busy_o !== 1'b1) $display("FAIL basic_run: eng_v %b busy %b want 0/1", bus.eng_v_o, bus.busy_o); else n_pass++;
    bus.req_v_i = 4'b1111;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b0000) $display("FAIL basic_noready: got %b want 0000", bus.req_ready_o); else n_pass++;
    bus.req_v_i = '0;
    repeat (6) tick();
    n_total++; if (bus.resp_v_o !== '0) $display("FAIL basic_early: resp_v got %b want 0000", bus.resp_v_o); else n_pass++;
    bus.eng_v_i = 1'b1;
    bus.eng_board_i = res;
    #1;
    n_total++; if (bus.eng_yumi_o !== 1'b1) $display("FAIL basic_yumi: got %b want 1", bus.eng_yumi_o); else n_pass++;
    tick();
    bus.eng_v_i = 1'b0;
    n_total++; if (bus.resp_v_o !== 4'b0001 || bus.resp_board_o !== res || bus.resp_err_o !== 1'b0) $display("FAIL basic_resp: got %b/%h/%b want 0001/%h/0", bus.resp_v_o, bus.resp_board_o, bus.resp_err_o, res); else n_pass++;
    tick();
    n_total++; if (bus.resp_v_o !== 4'b0001) $display("FAIL basic_stable: got %b want 0001", bus.resp_v_o); else n_pass++;
    bus.resp_yumi_i = 4'b0001;
    tick();
    bus.resp_yumi_i = '0;
    n_total++; if (bus.busy_o !== 1'b0 || bus.resp_v_o !== '0) $display("FAIL basic_done: busy %b resp_v %b want 0", bus.busy_o, bus.resp_v_o); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < N; i++) put(i, i + 1, board_of(i));
    bus.req_v_i = 4'b0010;
    #1;
    tick();
    bus.req_v_i = '0;
    bus.eng_ready_i = 1'b1;
    tick();
    bus.eng_ready_i = 1'b0;
    n_total++; if (bus.busy_o !== 1'b1 || bus.grant_id_o !== 2'd1) $display("FAIL midrun_busy: busy %b grant %0d want 1/1", bus.busy_o, bus.grant_id_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.busy_o !== 1'b0 || bus.resp_v_o !== '0 || bus.eng_v_o !== 1'b0 || bus.grant_id_o !== '0) $display("FAIL midrun_reset: busy %b resp_v %b eng_v %b grant %0d", bus.busy_o, bus.resp_v_o, bus.eng_v_o, bus.grant_id_o); else n_pass++;
    bus.req_v_i = 4'b0110;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b0010) $display("FAIL midrun_ready: got %b want 0010", bus.req_ready_o); else n_pass++;
    bus.req_v_i = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    bus.req_v_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      run_job(order[j], {32'hC0DE_0000, 32'(j)});
    end
    bus.req_v_i = '0;
  endtask

  task automatic test_wrap();
    bus.req_v_i = 4'b0010;
    run_job(1, 64'h1111);
    bus.req_v_i = 4'b0011;
    run_job(0, 64'h2222);
    bus.req_v_i = 4'b1011;
    run_job(1, 64'h3333);
    bus.req_v_i = '0;
  endtask

  task automatic test_bypass();
    logic [BB-1:0] bb;
    bb = 64'h0123_4567_89AB_CDEF;
    put(2, 0, bb);
    bus.req_v_i = 4'b0100;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b0100) $display("FAIL byp_ready: got %b want 0100", bus.req_ready_o); else n_pass++;
    tick();
    bus.req_v_i = '0;
    n_total++; if (bus.eng_v_o !== 1'b0 || bus.resp_v_o !== 4'b0100 || bus.resp_board_o !== bb) $display("FAIL byp_resp: eng_v %b resp %b/%h want 0/0100/%h", bus.eng_v_o, bus.resp_v_o, bus.resp_board_o, bb); else n_pass++;
    bus.resp_yumi_i = 4'b0010;
    tick();
    n_total++; if (bus.resp_v_o !== 4'b0100 || bus.busy_o !== 1'b1 || bus.eng_v_o !== 1'b0) $display("FAIL byp_ignore: resp %b busy %b eng_v %b want 0100/1/0", bus.resp_v_o, bus.busy_o, bus.eng_v_o); else n_pass++;
    bus.resp_yumi_i = 4'b0100;
    tick();
    bus.resp_yumi_i = '0;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL byp_done: busy got %b want 0", bus.busy_o); else n_pass++;
    bus.req_v_i = 4'b0101;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b0001) $display("FAIL byp_rrptr: got %b want 0001", bus.req_ready_o); else n_pass++;
    bus.req_v_i = '0;
    put(2, 3, board_of(2));
    tick();
  endtask

  task automatic test_stale();
    logic exp_yumi;
`ifdef BSG_CGOL_JOB_ARB_TIMEOUT_EN
    exp_yumi = 1'b1;
`else
    exp_yumi = 1'b0;
`endif
    bus.eng_v_i = 1'b1;
    bus.eng_board_i = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    n_total++; if (bus.eng_yumi_o !== exp_yumi) $display("FAIL stale_yumi: got %b want %b", bus.eng_yumi_o, exp_yumi); else n_pass++;
    tick();
    bus.eng_v_i = 1'b0;
    n_total++; if (bus.busy_o !== 1'b0 || bus.resp_v_o !== '0) $display("FAIL stale_state: busy %b resp %b want 0", bus.busy_o, bus.resp_v_o); else n_pass++;
  endtask

`ifdef BSG_CGOL_JOB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req_v_i = 4'b1000;
    #1;
    n_total++; if (bus.req_ready_o !== 4'b1000) $display("FAIL to_ready: got %b want 1000", bus.req_ready_o); else n_pass++;
    tick();
    bus.req_v_i = '0;
    bus.eng_ready_i = 1'b1;
    tick();
    bus.eng_ready_i = 1'b0;
    repeat (15) tick();
    n_total++; if (bus.resp_v_o !== '0 || bus.busy_o !== 1'b1) $display("FAIL to_early: resp %b busy %b want 0000/1", bus.resp_v_o, bus.busy_o); else n_pass++;
    tick();
    n_total++; if (bus.resp_v_o !== 4'b1000 || bus.resp_err_o !== 1'b1 || bus.resp_board_o !== board_of(3)) $display("FAIL to_resp: got %b/%b/%h want 1000/1/%h", bus.resp_v_o, bus.resp_err_o, bus.resp_board_o, board_of(3)); else n_pass++;
    bus.resp_yumi_i = 4'b1000;
    tick();
    bus.resp_yumi_i = '0;
    test_stale();
    bus.req_v_i = 4'b0001;
    run_job(0, 64'h5555_AAAA);
    bus.req_v_i = '0;
  endtask
`endif

  initial begin
    rst_n            = 1'b0;
    bus.req_v_i      = '0;
    bus.req_frames_i = '0;
    bus.req_board_i  = '0;
    bus.resp_yumi_i  = '0;
    bus.eng_ready_i  = 1'b0;
    bus.eng_v_i      = 1'b0;
    bus.eng_board_i  = '0;
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_round_robin();
    test_wrap();
    test_bypass();
`ifdef BSG_CGOL_JOB_ARB_TIMEOUT_EN
    bus.req_v_i = 4'b0001;
    run_job(0, 64'h7777);
    bus.req_v_i = 4'b0010;
    run_job(1, 64'h8888);
    bus.req_v_i = 4'b0100;
    run_job(2, 64'h9999);
    bus.req_v_i = '0;
    test_timeout();
`else
    test_stale();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
